// File: rtl/rotation_sin_cos_gen.sv
// Sprite rotation angle register with quarter-wave sin/cos lookup.
// The sin/cos pair and angle commit together once both lookups finish.
module rotation_sin_cos_gen #(
  parameter int ANGLE_STEPS = 64,
  parameter int FRAME_DIV   = 2,
  parameter int ONE         = 65536
) (
  input  logic                           clk,
  input  logic                           resetN,
  input  logic                           startOfFrame,
  input  logic                           rotate_left,
  input  logic                           rotate_right,
  input  logic                           load_angle,
  input  logic [$clog2(ANGLE_STEPS)-1:0] angle_in,
  output logic [$clog2(ANGLE_STEPS)-1:0] angle,
  output logic signed [17:0]             sin_val,
  output logic signed [17:0]             cos_val,
  output logic                           updated,
  output logic                           busy
);
  localparam int AW = $clog2(ANGLE_STEPS);
  localparam int QW = AW - 1;
  localparam int Q = ANGLE_STEPS / 4;
  localparam int STRIDE = 64 / ANGLE_STEPS;
  localparam int CW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(FRAME_DIV - 1);
  localparam logic [AW-1:0] QTR = AW'(Q);

  typedef enum logic [2:0] {
    IDLE, SIN_RD, SIN_CAP, COS_RD, COS_CAP, COMMIT
  } state_t;

  state_t state, state_n;

  logic [AW-1:0]     work;
  logic [CW-1:0]     frame_cnt;
  logic [QW-1:0]     addr_q;
  logic              neg_q;
  logic signed [17:0] sin_tmp, cos_tmp;
  logic [4:0]        fine_idx;
  logic signed [17:0] rom_mag, rom_signed;
  logic [AW-1:0]     cos_idx, step_angle;
  logic              one_key;

  // 64-step quarter-wave base table; coarser tables subsample it
  function automatic logic [16:0] q64(input logic [4:0] i);
    case (i)
      5'd0:    return 17'd0;
      5'd1:    return 17'd6424;
      5'd2:    return 17'd12785;
      5'd3:    return 17'd19024;
      5'd4:    return 17'd25080;
      5'd5:    return 17'd30893;
      5'd6:    return 17'd36410;
      5'd7:    return 17'd41576;
      5'd8:    return 17'd46341;
      5'd9:    return 17'd50660;
      5'd10:   return 17'd54491;
      5'd11:   return 17'd57798;
      5'd12:   return 17'd60547;
      5'd13:   return 17'd62714;
      5'd14:   return 17'd64277;
      5'd15:   return 17'd65220;
      5'd16:   return 17'd65536;
      default: return 17'd0;
    endcase
  endfunction

  function automatic logic signed [17:0] scale(input logic [16:0] v);
    longint p;
    p = (longint'(v) * ONE + 32768) / 65536;
    return 18'(p);
  endfunction

  function automatic logic [QW-1:0] lut_addr(input logic [AW-1:0] a);
    logic [QW-1:0] r;
    r = {1'b0, a[AW-3:0]};
    return a[AW-2] ? QW'(Q) - r : r;
  endfunction

  assign fine_idx   = 5'(int'(addr_q) * STRIDE);
  assign rom_mag    = scale(q64(fine_idx));
  assign rom_signed = neg_q ? -rom_mag : rom_mag;
  assign cos_idx    = work + QTR;
  assign step_angle = rotate_right ? work + AW'(1) : work - AW'(1);
  assign one_key    = rotate_left ^ rotate_right;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (load_angle || startOfFrame) state_n = SIN_RD;
      SIN_RD:  state_n = SIN_CAP;
      SIN_CAP: state_n = COS_RD;
      COS_RD:  state_n = COS_CAP;
      COS_CAP: state_n = COMMIT;
      COMMIT:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      work      <= '0;
      frame_cnt <= CNT_MAX;
      addr_q    <= '0;
      neg_q     <= 1'b0;
      sin_tmp   <= '0;
      cos_tmp   <= '0;
      angle     <= '0;
      sin_val   <= '0;
      cos_val   <= 18'(ONE);
      updated   <= 1'b0;
    end else begin
      updated <= (state == COMMIT);
      case (state)
        IDLE: begin
          if (load_angle) begin
            work      <= angle_in;
            frame_cnt <= CNT_MAX;
          end else if (startOfFrame) begin
            if (!one_key) begin
              frame_cnt <= CNT_MAX;
            end else if (frame_cnt == CNT_MAX) begin
              work      <= step_angle;
              frame_cnt <= '0;
            end else begin
              frame_cnt <= frame_cnt + CW'(1);
            end
          end
        end
        SIN_RD: begin
          addr_q <= lut_addr(work);
          neg_q  <= work[AW-1];
        end
        SIN_CAP: sin_tmp <= rom_signed;
        COS_RD: begin
          addr_q <= lut_addr(cos_idx);
          neg_q  <= cos_idx[AW-1];
        end
        COS_CAP: cos_tmp <= rom_signed;
        COMMIT: begin
          angle   <= work;
          sin_val <= sin_tmp;
          cos_val <= cos_tmp;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_rotation_sin_cos_gen.sv
// Directed bench for rotation_sin_cos_gen with a scoreboard of
// expected commits checked against each updated pulse.
module tb_rotation_sin_cos_gen;
  logic        clk = 1'b0;
  logic        resetN;
  logic        startOfFrame;
  logic        rotate_left;
  logic        rotate_right;
  logic        load_angle;
  logic [5:0]  angle_in;
  logic [5:0]  angle;
  logic signed [17:0] sin_val;
  logic signed [17:0] cos_val;
  logic        updated;
  logic        busy;

  rotation_sin_cos_gen dut (
    .clk(clk),
    .resetN(resetN),
    .startOfFrame(startOfFrame),
    .rotate_left(rotate_left),
    .rotate_right(rotate_right),
    .load_angle(load_angle),
    .angle_in(angle_in),
    .angle(angle),
    .sin_val(sin_val),
    .cos_val(cos_val),
    .updated(updated),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ang;
    int s;
    int c;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int upd_cnt = 0;
  int m_angle = 0;
  int m_cnt = 1;

  always @(posedge clk) cyc++;

  function automatic int qv(int a);
    real x;
    x = 65536.0 * $sin(6.283185307179586 * a / 64.0);
    return int'($floor(x + 0.5));
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (resetN && updated) begin
      exp_t e;
      upd_cnt++;
      if (sb.size() == 0) begin
        chk("spurious_update", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("angle", angle, e.ang);
        chk("sin_val", sin_val, e.s);
        chk("cos_val", cos_val, e.c);
        chk("latency", cyc - e.cyc, 6);
        chk("busy_in_upd", busy, 0);
      end
    end
  end

  task automatic frame(input logic sof, input logic ld,
                       input logic [5:0] ain, input logic l,
                       input logic r);
    exp_t e;
    @(negedge clk);
    startOfFrame = sof;
    load_angle   = ld;
    angle_in     = ain;
    rotate_left  = l;
    rotate_right = r;
    if (ld) begin
      m_angle = ain;
      m_cnt   = 1;
    end else if (sof) begin
      if (l ^ r) begin
        if (m_cnt == 1) begin
          m_angle = (m_angle + (r ? 1 : 63)) % 64;
          m_cnt   = 0;
        end else begin
          m_cnt = m_cnt + 1;
        end
      end else begin
        m_cnt = 1;
      end
    end
    e.ang = m_angle;
    e.s   = qv(m_angle);
    e.c   = qv((m_angle + 16) % 64);
    e.cyc = cyc;
    sb.push_back(e);
    @(negedge clk);
    startOfFrame = 1'b0;
    load_angle   = 1'b0;
    chk("busy_after_e0", busy, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && sb.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int u0;
    resetN       = 1'b0;
    startOfFrame = 1'b0;
    rotate_left  = 1'b0;
    rotate_right = 1'b0;
    load_angle   = 1'b0;
    angle_in     = '0;
    repeat (3) @(negedge clk);
    resetN = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_angle", angle, 0);
    chk("rst_sin", sin_val, 0);
    chk("rst_cos", cos_val, 65536);
    chk("rst_updated", updated, 0);
    chk("rst_busy", busy, 0);

    frame(1, 0, 0, 0, 1);
    drain();
    chk("r1_angle", angle, 1);
    chk("r1_sin", sin_val, 6424);
    chk("r1_cos", cos_val, 65220);
    frame(1, 0, 0, 0, 1);
    drain();
    chk("r2_angle", angle, 1);
    frame(1, 0, 0, 0, 1);
    drain();
    chk("r3_angle", angle, 2);

    frame(0, 1, 16, 0, 0);
    drain();
    chk("ld16_sin", sin_val, 65536);
    chk("ld16_cos", cos_val, 0);
    frame(0, 1, 8, 0, 0);
    drain();
    chk("ld8_sin", sin_val, 46341);
    chk("ld8_cos", cos_val, 46341);
    frame(0, 1, 32, 0, 0);
    drain();
    chk("ld32_sin", sin_val, 0);
    chk("ld32_cos", cos_val, -65536);

    frame(0, 1, 0, 0, 0);
    drain();
    frame(1, 0, 0, 1, 0);
    drain();
    chk("left_angle", angle, 63);
    chk("left_sin", sin_val, -6424);
    chk("left_cos", cos_val, 65220);
    frame(1, 0, 0, 0, 0);
    drain();
    frame(1, 0, 0, 0, 1);
    drain();
    chk("wrap_angle", angle, 0);

    u0 = upd_cnt;
    frame(1, 0, 0, 1, 1);
    drain();
    frame(1, 0, 0, 1, 1);
    drain();
    chk("both_angle", angle, 0);
    chk("both_upd", upd_cnt - u0, 2);

    frame(0, 1, 10, 0, 0);
    drain();
    u0 = upd_cnt;
    frame(1, 0, 0, 0, 0);
    startOfFrame = 1'b0;
    @(negedge clk);
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    drain();
    repeat (8) @(negedge clk);
    chk("repulse_upd", upd_cnt - u0, 1);
    chk("repulse_angle", angle, 10);

    frame(1, 1, 5, 0, 1);
    drain();
    chk("ld_wins_angle", angle, 5);

    u0 = upd_cnt;
    @(negedge clk);
    startOfFrame = 1'b1;
    rotate_right = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetN = 1'b0;
    #1;
    chk("mid_rst_angle", angle, 0);
    chk("mid_rst_sin", sin_val, 0);
    chk("mid_rst_cos", cos_val, 65536);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_upd", updated, 0);
    rotate_right = 1'b0;
    @(negedge clk);
    resetN  = 1'b1;
    m_angle = 0;
    m_cnt   = 1;
    repeat (10) @(negedge clk);
    chk("no_upd_after_rst", upd_cnt - u0, 0);

    frame(1, 0, 0, 0, 1);
    drain();
    chk("post_rst_angle", angle, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
